smart_vending_machine: RTL and testbench

//  Order packer for the vending datapath. Collects 1-4 snack codes per order

---
 rtl/smart_vending_machine.sv | 112 +++++++++++
 tb/tb_smart_vending_machine.sv | 129 ++++++++++++
 2 files changed

// File: rtl/smart_vending_machine.sv
// Order packer: gathers 1..MAX_ITEMS snack codes from a serial item stream
// and emits them as one packed word with a single-cycle valid_o pulse.
//
// Handshake: valid-only stream, there is no ready. The packer accepts every
// beat on which valid_i is high. Once an order has started, its beats must
// arrive on consecutive cycles. A low valid_i inside an order aborts that
// order. valid_o is a one-cycle pulse, and packed_snack is meaningful while
// valid_o is high. Between pulses, packed_snack keeps the last completed order.
module smart_vending_machine #(
    parameter int SNACK_W   = 2,
    parameter int MAX_ITEMS = 4,
    parameter int OUT_W     = SNACK_W * MAX_ITEMS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         valid_i,
    input  logic [SNACK_W-1:0]           snack,
    input  logic [$clog2(MAX_ITEMS)-1:0] quantity,
    output logic                         valid_o,
    output logic [OUT_W-1:0]             packed_snack
);

    localparam int CNT_W = $clog2(MAX_ITEMS);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;   // items stored so far in this order
    logic [CNT_W-1:0]   len_q,   len_d;     // order length minus one
    logic [OUT_W-1:0]   shift_q, shift_d;   // partial order being assembled
    logic               valid_q, valid_d;
    logic [OUT_W-1:0]   packed_q, packed_d;

    // State and datapath registers; reset discards any partial order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            len_q    <= '0;
            shift_q  <= '0;
            valid_q  <= 1'b0;
            packed_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            len_q    <= len_d;
            shift_q  <= shift_d;
            valid_q  <= valid_d;
            packed_q <= packed_d;
        end
    end

    // Next-state logic: latch the order length on the first beat, place each
    // item at its slot, and publish the word on the edge of the last item
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        len_d    = len_q;
        shift_d  = shift_q;
        valid_d  = 1'b0;
        packed_d = packed_q;

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    len_d                 = quantity;
                    shift_d               = '0;
                    shift_d[SNACK_W-1:0]  = snack;
                    count_d               = CNT_W'(1);
                    if (quantity == '0) begin
                        // Single-item order completes immediately; stay in IDLE
                        valid_d  = 1'b1;
                        packed_d = shift_d;
                        count_d  = '0;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (valid_i) begin
                    // The first beat's quantity governs the order, so quantity is ignored here
                    shift_d[int'(count_q)*SNACK_W +: SNACK_W] = snack;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == len_q) begin
                        valid_d  = 1'b1;
                        packed_d = shift_d;
                        count_d  = '0;
                        state_d  = IDLE;
                    end
                end else begin
                    // A gap inside an order aborts it without any output
                    state_d = IDLE;
                    count_d = '0;
                    shift_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                shift_d = '0;
            end
        endcase
    end

    assign valid_o      = valid_q;
    assign packed_snack = packed_q;

endmodule

// File: tb/tb_smart_vending_machine.sv
// Directed testbench for smart_vending_machine. Each step drives one beat on
// the falling edge and checks both outputs just after the next rising edge.
module tb_smart_vending_machine;

    logic       clk;
    logic       rst_n;
    logic       valid_i;
    logic [1:0] snack;
    logic [1:0] quantity;
    logic       valid_o;
    logic [7:0] packed_snack;

    int checks = 0;
    int errors = 0;

    smart_vending_machine dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .snack        (snack),
        .quantity     (quantity),
        .valid_o      (valid_o),
        .packed_snack (packed_snack)
    );

    // Clock: 10 time-unit period, rising edge is active
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_out(input string tag, input logic exp_v, input logic [7:0] exp_p);
        checks++;
        assert (valid_o === exp_v) else begin
            errors++;
            $error("FAIL %s valid_o got %0b exp %0b", tag, valid_o, exp_v);
        end
        checks++;
        assert (packed_snack === exp_p) else begin
            errors++;
            $error("FAIL %s packed_snack got %h exp %h", tag, packed_snack, exp_p);
        end
    endtask

    // One cycle: drive the beat on the falling edge, check 1 unit after the rising edge
    task automatic step(input string tag, input logic v, input logic [1:0] q,
                        input logic [1:0] s, input logic exp_v, input logic [7:0] exp_p);
        @(negedge clk);
        valid_i  = v;
        quantity = q;
        snack    = s;
        @(posedge clk);
        #1;
        check_out(tag, exp_v, exp_p);
    endtask

    initial begin
        rst_n    = 1'b0;
        valid_i  = 1'b0;
        snack    = 2'b00;
        quantity = 2'b00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step("idle_after_reset", 1'b0, 2'd0, 2'b00, 1'b0, 8'h00);

        // Single-item order
        step("q0_s3",      1'b1, 2'd0, 2'b11, 1'b1, 8'h03);
        step("q0_hold",    1'b0, 2'd0, 2'b00, 1'b0, 8'h03);

        // Two items; the second beat's quantity must be ignored
        step("q1_b0",      1'b1, 2'd1, 2'b01, 1'b0, 8'h03);
        step("q1_b1",      1'b1, 2'd3, 2'b10, 1'b1, 8'h09);
        step("q1_hold",    1'b0, 2'd0, 2'b00, 1'b0, 8'h09);

        // Four items
        step("q3_b0",      1'b1, 2'd3, 2'b00, 1'b0, 8'h09);
        step("q3_b1",      1'b1, 2'd0, 2'b01, 1'b0, 8'h09);
        step("q3_b2",      1'b1, 2'd0, 2'b10, 1'b0, 8'h09);
        step("q3_b3",      1'b1, 2'd0, 2'b11, 1'b1, 8'hE4);

        // Three items start back-to-back after the previous order
        step("q2_b0",      1'b1, 2'd2, 2'b10, 1'b0, 8'hE4);
        step("q2_b1",      1'b1, 2'd0, 2'b11, 1'b0, 8'hE4);
        step("q2_b2",      1'b1, 2'd0, 2'b01, 1'b1, 8'h1E);

        // Back-to-back: a single-item order, then a two-item order with no gap
        step("b2b_q0",     1'b1, 2'd0, 2'b01, 1'b1, 8'h01);
        step("b2b_q1_b0",  1'b1, 2'd1, 2'b11, 1'b0, 8'h01);
        step("b2b_q1_b1",  1'b1, 2'd0, 2'b00, 1'b1, 8'h03);
        step("b2b_idle",   1'b0, 2'd0, 2'b00, 1'b0, 8'h03);

        // Abort: two beats of a four-item order, then a gap
        step("abort_b0",   1'b1, 2'd3, 2'b01, 1'b0, 8'h03);
        step("abort_b1",   1'b1, 2'd0, 2'b10, 1'b0, 8'h03);
        step("abort_gap",  1'b0, 2'd0, 2'b00, 1'b0, 8'h03);
        step("abort_gap2", 1'b0, 2'd0, 2'b00, 1'b0, 8'h03);
        step("after_abort",1'b1, 2'd0, 2'b10, 1'b1, 8'h02);

        // Sustained single-item orders give a pulse on every cycle
        step("sust_0",     1'b1, 2'd0, 2'b01, 1'b1, 8'h01);
        step("sust_1",     1'b1, 2'd0, 2'b10, 1'b1, 8'h02);
        step("sust_2",     1'b1, 2'd0, 2'b11, 1'b1, 8'h03);
        step("sust_3",     1'b1, 2'd0, 2'b00, 1'b1, 8'h00);
        step("sust_4",     1'b1, 2'd0, 2'b10, 1'b1, 8'h02);

        // Reset in the middle of an order clears the outputs at once
        step("mid_b0",     1'b1, 2'd3, 2'b11, 1'b0, 8'h02);
        step("mid_b1",     1'b1, 2'd0, 2'b11, 1'b0, 8'h02);
        @(negedge clk);
        valid_i = 1'b0;
        rst_n   = 1'b0;
        #1;
        check_out("mid_reset", 1'b0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // The next order must pack cleanly, with no leftover items
        step("post_rst_b0",1'b1, 2'd1, 2'b01, 1'b0, 8'h00);
        step("post_rst_b1",1'b1, 2'd0, 2'b01, 1'b1, 8'h05);
        step("post_rst_id",1'b0, 2'd0, 2'b00, 1'b0, 8'h05);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
